// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide engine.
//   mdState_t : control FSM state encoding (3 bits)
//   COUNT_W   : width of the iteration counter
package mult_div_unit_pkg;

    localparam int COUNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdState_t;

endpackage

// File: rtl/restoring_div_core.sv
// Unsigned restoring divider datapath, one quotient bit per step.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture dividend/divisor magnitudes, clear remainder
//   step                perform one shift / trial-subtract / restore iteration
//   dividend, divisor   unsigned magnitudes (sampled on load)
//   quotient, remainder unsigned results, valid after WIDTH steps
module restoring_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the remainder while the new quotient bit enters at the LSB.
    always_comb begin
        shifted = {remReg, quoReg[WIDTH-1]};
        trial   = shifted - {1'b0, divisorReg};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divisorReg <= '0;
            quoReg     <= '0;
            remReg     <= '0;
        end else if (load) begin
            divisorReg <= divisor;
            quoReg     <= dividend;
            remReg     <= '0;
        end else if (step) begin
            if (trial[WIDTH]) begin
                remReg <= shifted[WIDTH-1:0];
                quoReg <= {quoReg[WIDTH-2:0], 1'b0};
            end else begin
                remReg <= trial[WIDTH-1:0];
                quoReg <= {quoReg[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign quotient  = quoReg;
    assign remainder = remReg;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV engine owning the HI/LO registers.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for mult_start / div_start
// MULT  | Booth radix-2 iteration, one per cycle, WIDTH iterations
// DIV   | restoring divide on magnitudes, WIDTH iterations
// FIX   | apply signs to quotient/remainder, write LO/HI
// DONE  | done pulse (with div_zero when divisor was 0), back to IDLE
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mult_start, div_start one-cycle start pulses (multiply wins if both)
//   a, b                  operands, sampled only on an accepted start
//   busy                  high in MULT, DIV, FIX
//   done, div_zero        one-cycle completion pulses
//   hi, lo                HI/LO registers
module mult_div_unit import mult_div_unit_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [COUNT_W-1:0] LAST_ITER = COUNT_W'(WIDTH - 1);

    mdState_t state;
    mdState_t stateNext;

    logic [COUNT_W-1:0] count;
    logic               lastIter;

    // Booth register {acc, Q, q-1}. The accumulator carries one guard bit so
    // subtracting a multiplicand of -2^(WIDTH-1) cannot overflow.
    logic [2*WIDTH+1:0] booth;
    logic [2*WIDTH+1:0] boothNext;
    logic [WIDTH:0]     multiplicand;
    logic [WIDTH:0]     accSum;

    logic             negQuot;
    logic             negRem;
    logic             divZeroFlag;
    logic             divLoad;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] quotMag;
    logic [WIDTH-1:0] remMag;

    assign lastIter = (count == LAST_ITER);
    assign absA     = a[WIDTH-1] ? ('0 - a) : a;
    assign absB     = b[WIDTH-1] ? ('0 - b) : b;
    assign divLoad  = (state == ST_IDLE) && div_start && !mult_start && (b != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE: begin
                if (mult_start) begin
                    stateNext = ST_MULT;
                end else if (div_start) begin
                    stateNext = (b == '0) ? ST_DONE : ST_DIV;
                end
            end
            ST_MULT: if (lastIter) stateNext = ST_DONE;
            ST_DIV:  if (lastIter) stateNext = ST_FIX;
            ST_FIX:  stateNext = ST_DONE;
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        accSum = booth[2*WIDTH+1:WIDTH+1];
        unique case (booth[1:0])
            2'b01:   accSum = booth[2*WIDTH+1:WIDTH+1] + multiplicand;
            2'b10:   accSum = booth[2*WIDTH+1:WIDTH+1] - multiplicand;
            default: accSum = booth[2*WIDTH+1:WIDTH+1];
        endcase
        boothNext = {accSum[WIDTH], accSum, booth[WIDTH:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            booth        <= '0;
            multiplicand <= '0;
            negQuot      <= 1'b0;
            negRem       <= 1'b0;
            divZeroFlag  <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (mult_start) begin
                        multiplicand <= {a[WIDTH-1], a};
                        booth        <= {{(WIDTH+1){1'b0}}, b, 1'b0};
                        divZeroFlag  <= 1'b0;
                    end else if (div_start) begin
                        negQuot     <= a[WIDTH-1] ^ b[WIDTH-1];
                        negRem      <= a[WIDTH-1];
                        divZeroFlag <= (b == '0);
                    end
                end
                ST_MULT: begin
                    booth <= boothNext;
                    count <= count + 1'b1;
                    if (lastIter) begin
                        hi <= boothNext[2*WIDTH:WIDTH+1];
                        lo <= boothNext[WIDTH:1];
                    end
                end
                ST_DIV: begin
                    count <= count + 1'b1;
                end
                ST_FIX: begin
                    lo <= negQuot ? ('0 - quotMag) : quotMag;
                    hi <= negRem  ? ('0 - remMag)  : remMag;
                end
                default: begin
                end
            endcase
        end
    end

    restoring_div_core #(.WIDTH(WIDTH)) uDivCore (
        .clk       (clk),
        .reset     (reset),
        .load      (divLoad),
        .step      (state == ST_DIV),
        .dividend  (absA),
        .divisor   (absB),
        .quotient  (quotMag),
        .remainder (remMag)
    );

    assign busy     = (state == ST_MULT) || (state == ST_DIV) || (state == ST_FIX);
    assign done     = (state == ST_DONE);
    assign div_zero = (state == ST_DONE) && divZeroFlag;

endmodule
